ddc_tune_ctrl: RTL and testbench

//  Sequencer for the NCO -> mixer -> dual CIC receive chain. Owns the NCO phase increment and the
//  CIC gain setting, and applies retune requests atomically. After reset or a retune it discards
//  CIC output samples until the filters have settled. It pairs the I/Q CIC ticks into IQ words and

---
 rtl/ddc_tune_ctrl_if.sv | 37 +++
 rtl/ddc_tune_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_ddc_tune_ctrl.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/ddc_tune_ctrl_if.sv
// Tune, CIC sample and IQ output signals for ddc_tune_ctrl.
// The master side drives requests and samples; the slave side is the controller.
interface ddc_tune_ctrl_if;
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 40;
    localparam int unsigned GW = 3;

    logic          tune_req;
    logic [PW-1:0] tune_phase_inc;
    logic [GW-1:0] tune_gain;
    logic          tune_busy;
    logic [PW-1:0] nco_phase_inc;
    logic [GW-1:0] cic_gain;
    logic [DW-1:0] xI_in;
    logic [DW-1:0] xQ_in;
    logic          tick_I;
    logic          tick_Q;
    logic          iq_valid;
    logic          iq_ready;
    logic [DW-1:0] iq_I;
    logic [DW-1:0] iq_Q;
    logic          clr_status;
    logic          overflow;
    logic          pair_err;

    modport master (
        output tune_req, tune_phase_inc, tune_gain, xI_in, xQ_in, tick_I, tick_Q,
               iq_ready, clr_status,
        input  tune_busy, nco_phase_inc, cic_gain, iq_valid, iq_I, iq_Q, overflow, pair_err
    );

    modport slave (
        input  tune_req, tune_phase_inc, tune_gain, xI_in, xQ_in, tick_I, tick_Q,
               iq_ready, clr_status,
        output tune_busy, nco_phase_inc, cic_gain, iq_valid, iq_I, iq_Q, overflow, pair_err
    );
endinterface

// File: rtl/ddc_tune_ctrl.sv
// DDC retune sequencer: atomic NCO/CIC updates, post-retune settling discard,
// I/Q tick pairing and a small IQ output FIFO with sticky error flags.
module ddc_tune_ctrl #(
    parameter logic [39:0] DEFAULT_PHASE_INC = 40'h2656abde3,
    parameter int unsigned SETTLE_TICKS      = 8,
    parameter int unsigned FIFO_DEPTH        = 4
) (
    input  logic           CLK,
    input  logic           RSTb,
    ddc_tune_ctrl_if.slave bus
);
    localparam int unsigned DW = 16;
    localparam int unsigned PW = 40;
    localparam int unsigned GW = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned NW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_RUN    = 2'd1,
        ST_APPLY  = 2'd2
    } state_t;

    typedef struct packed {
        logic [DW-1:0] i;
        logic [DW-1:0] q;
    } iq_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic          r_busy;
    logic [PW-1:0] r_phase_inc;
    logic [GW-1:0] r_gain;

    logic          r_half_i, r_half_q;
    logic [DW-1:0] r_hold_i, r_hold_q;

    iq_t           r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_rd_ptr, r_wr_ptr, w_rd_nxt, w_wr_nxt;
    logic [NW-1:0] r_count, w_count_nxt, w_count_popped;
    logic          r_iq_valid;
    iq_t           r_head, w_head_nxt;
    logic          r_overflow, r_pair_err;

    logic          w_have_i, w_have_q, w_pair_done;
    iq_t           w_pair;
    logic          w_tune_acc, w_flush, w_pop, w_full;
    logic          w_push_req, w_push, w_ovf_set, w_perr_set;

    // Pairing and FIFO control decode
    always_comb begin
        w_have_i    = bus.tick_I | r_half_i;
        w_have_q    = bus.tick_Q | r_half_q;
        w_pair_done = w_have_i & w_have_q;
        w_pair.i    = bus.tick_I ? bus.xI_in : r_hold_i;
        w_pair.q    = bus.tick_Q ? bus.xQ_in : r_hold_q;
        w_tune_acc  = (r_state == ST_RUN) & bus.tune_req;
        w_flush     = w_tune_acc | (r_state == ST_APPLY);
        w_pop       = r_iq_valid & bus.iq_ready & ~w_flush;
        w_full      = (r_count == NW'(FIFO_DEPTH));
        w_push_req  = w_pair_done & (r_state == ST_RUN) & ~w_flush;
        // a pop frees the slot in the same cycle, so full+pop still accepts
        w_push      = w_push_req & (~w_full | w_pop);
        w_ovf_set   = w_push_req & w_full & ~w_pop;
        w_perr_set  = (bus.tick_I & r_half_i) | (bus.tick_Q & r_half_q);
    end

    // FSM next state
    always_comb begin
        w_state_nxt      = r_state;
        w_settle_cnt_nxt = r_settle_cnt;
        case (r_state)
            ST_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_state_nxt = ST_RUN;
                end else if (w_pair_done) begin
                    w_settle_cnt_nxt = r_settle_cnt - CW'(1);
                    if (r_settle_cnt == CW'(1)) w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (bus.tune_req) w_state_nxt = ST_APPLY;
            end
            ST_APPLY: begin
                w_state_nxt      = ST_SETTLE;
                w_settle_cnt_nxt = CW'(SETTLE_TICKS);
            end
            default: begin
                w_state_nxt      = ST_SETTLE;
                w_settle_cnt_nxt = CW'(SETTLE_TICKS);
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state      <= ST_SETTLE;
            r_settle_cnt <= CW'(SETTLE_TICKS);
            r_busy       <= 1'b1;
            r_phase_inc  <= DEFAULT_PHASE_INC;
            r_gain       <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_busy       <= (w_state_nxt != ST_RUN);
            if (w_tune_acc) begin
                r_phase_inc <= bus.tune_phase_inc;
                r_gain      <= bus.tune_gain;
            end
        end
    end

    // Half-pair holding registers
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_half_i <= 1'b0;
            r_half_q <= 1'b0;
            r_hold_i <= '0;
            r_hold_q <= '0;
        end else begin
            if (bus.tick_I) r_hold_i <= bus.xI_in;
            if (bus.tick_Q) r_hold_q <= bus.xQ_in;
            if (w_flush || w_pair_done) begin
                r_half_i <= 1'b0;
                r_half_q <= 1'b0;
            end else begin
                if (bus.tick_I) r_half_i <= 1'b1;
                if (bus.tick_Q) r_half_q <= 1'b1;
            end
        end
    end

    // FIFO pointer/count/head next state
    always_comb begin
        w_count_popped = r_count - NW'(w_pop);
        w_count_nxt    = w_count_popped + NW'(w_push);
        w_rd_nxt       = r_rd_ptr + AW'(w_pop);
        w_wr_nxt       = r_wr_ptr + AW'(w_push);
        // a push into an empty-after-pop FIFO lands directly at the head
        if (w_push && (w_count_popped == '0)) w_head_nxt = w_pair;
        else                                  w_head_nxt = r_mem[w_rd_nxt];
        if (w_flush) begin
            w_count_nxt = '0;
            w_rd_nxt    = '0;
            w_wr_nxt    = '0;
            w_head_nxt  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) r_mem[r_wr_ptr] <= w_pair;
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_iq_valid <= 1'b0;
            r_head     <= '0;
        end else begin
            r_rd_ptr   <= w_rd_nxt;
            r_wr_ptr   <= w_wr_nxt;
            r_count    <= w_count_nxt;
            r_iq_valid <= (w_count_nxt != '0);
            r_head     <= w_head_nxt;
        end
    end

    // Sticky status: a set in the same cycle as clear wins
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_overflow <= 1'b0;
            r_pair_err <= 1'b0;
        end else begin
            if (w_ovf_set)           r_overflow <= 1'b1;
            else if (bus.clr_status) r_overflow <= 1'b0;
            if (w_perr_set)          r_pair_err <= 1'b1;
            else if (bus.clr_status) r_pair_err <= 1'b0;
        end
    end

    assign bus.tune_busy     = r_busy;
    assign bus.nco_phase_inc = r_phase_inc;
    assign bus.cic_gain      = r_gain;
    assign bus.iq_valid      = r_iq_valid;
    assign bus.iq_I          = r_head.i;
    assign bus.iq_Q          = r_head.q;
    assign bus.overflow      = r_overflow;
    assign bus.pair_err      = r_pair_err;
endmodule

// File: tb/tb_ddc_tune_ctrl.sv
// Directed bench for ddc_tune_ctrl: settle discard, retune, FIFO full/overflow,
// pairing, sticky flags and mid-stream reset.
module tb_ddc_tune_ctrl;
    localparam logic [39:0] DEF_INC = 40'h2656abde3;

    logic CLK = 1'b0;
    logic RSTb;
    int   n_pass = 0;
    int   n_total = 0;

    ddc_tune_ctrl_if bus ();

    ddc_tune_ctrl #(
        .DEFAULT_PHASE_INC (DEF_INC),
        .SETTLE_TICKS      (8),
        .FIFO_DEPTH        (4)
    ) u_dut (
        .CLK  (CLK),
        .RSTb (RSTb),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pair(input logic [15:0] i, input logic [15:0] q);
        bus.tick_I = 1'b1; bus.xI_in = i;
        bus.tick_Q = 1'b1; bus.xQ_in = q;
        step();
        bus.tick_I = 1'b0;
        bus.tick_Q = 1'b0;
    endtask

    task automatic tick_i(input logic [15:0] i);
        bus.tick_I = 1'b1; bus.xI_in = i;
        step();
        bus.tick_I = 1'b0;
    endtask

    task automatic tick_q(input logic [15:0] q);
        bus.tick_Q = 1'b1; bus.xQ_in = q;
        step();
        bus.tick_Q = 1'b0;
    endtask

    task automatic pop();
        bus.iq_ready = 1'b1;
        step();
        bus.iq_ready = 1'b0;
    endtask

    task automatic clear();
        bus.clr_status = 1'b1;
        step();
        bus.clr_status = 1'b0;
    endtask

    initial begin
        RSTb = 1'b0;
        bus.tune_req = 1'b0; bus.tune_phase_inc = '0; bus.tune_gain = '0;
        bus.xI_in = '0; bus.xQ_in = '0; bus.tick_I = 1'b0; bus.tick_Q = 1'b0;
        bus.iq_ready = 1'b0; bus.clr_status = 1'b0;
        step(); step();

        check("rst_valid", bus.iq_valid, 0);
        check("rst_inc", bus.nco_phase_inc, DEF_INC);
        check("rst_gain", bus.cic_gain, 0);
        check("rst_busy", bus.tune_busy, 1);
        check("rst_iqI", bus.iq_I, 0);
        check("rst_flags", {bus.overflow, bus.pair_err}, 0);

        // tune_req right after reset is ignored
        RSTb = 1'b1;
        bus.tune_req = 1'b1; bus.tune_phase_inc = 40'h55; bus.tune_gain = 3'd5;
        step();
        bus.tune_req = 1'b0;
        check("settle_tune_ignored", bus.nco_phase_inc, DEF_INC);

        for (int k = 1; k <= 8; k++) begin
            pair(16'(k), 16'(16'hFF00 + k));
            if (k == 7) check("settle7_busy", bus.tune_busy, 1);
        end
        check("settle8_busy", bus.tune_busy, 0);
        check("settle8_valid", bus.iq_valid, 0);
        pair(16'h0009, 16'hFFF7);
        check("first_valid", bus.iq_valid, 1);
        check("first_data", {bus.iq_I, bus.iq_Q}, 32'h0009FFF7);
        pop();
        check("first_popped", bus.iq_valid, 0);

        // retune flushes a pending entry
        pair(16'hAAAA, 16'h5555);
        check("pre_tune_valid", bus.iq_valid, 1);
        bus.tune_req = 1'b1; bus.tune_phase_inc = 40'h1000000000; bus.tune_gain = 3'd3;
        step();
        bus.tune_req = 1'b0;
        check("tune_inc", bus.nco_phase_inc, 40'h1000000000);
        check("tune_gain", bus.cic_gain, 3);
        check("tune_flush", bus.iq_valid, 0);
        check("tune_busy", bus.tune_busy, 1);
        pair(16'h0BAD, 16'h0BAD);
        bus.tune_req = 1'b1; bus.tune_phase_inc = 40'hABCDE; bus.tune_gain = 3'd1;
        step();
        bus.tune_req = 1'b0;
        check("busy_tune_ignored", bus.nco_phase_inc, 40'h1000000000);
        for (int k = 0; k < 8; k++) begin
            pair(16'(k), 16'(k));
            if (k == 6) check("retune_settle7_busy", bus.tune_busy, 1);
        end
        check("retune_settle8_busy", bus.tune_busy, 0);
        check("retune_settle8_valid", bus.iq_valid, 0);

        // overflow: 5 pairs into a 4-deep FIFO with no consumer
        for (int k = 0; k < 5; k++) begin
            pair(16'(16'h0100 + k), 16'(16'h0200 + k));
            if (k == 3) check("ovf_before", bus.overflow, 0);
        end
        check("ovf_set", bus.overflow, 1);
        check("ovf_head0", {bus.iq_I, bus.iq_Q}, 32'h01000200);
        step();
        check("ovf_stall_hold", {bus.iq_I, bus.iq_Q}, 32'h01000200);
        bus.iq_ready = 1'b1;
        for (int k = 1; k < 4; k++) begin
            step();
            check("ovf_pop_order", {bus.iq_I, bus.iq_Q}, {16'(16'h0100 + k), 16'(16'h0200 + k)});
        end
        step();
        bus.iq_ready = 1'b0;
        check("ovf_drained", bus.iq_valid, 0);
        clear();
        check("ovf_cleared", bus.overflow, 0);

        // simultaneous pop and push on a full FIFO
        for (int k = 0; k < 4; k++) pair(16'(16'h0040 + k), 16'h0);
        bus.iq_ready = 1'b1;
        pair(16'h0044, 16'h0);
        check("full_pp_no_ovf", bus.overflow, 0);
        check("full_pp_head", bus.iq_I, 16'h0041);
        for (int k = 2; k <= 4; k++) begin
            step();
            check("full_pp_order", bus.iq_I, 16'(16'h0040 + k));
        end
        step();
        bus.iq_ready = 1'b0;
        check("full_pp_drained", bus.iq_valid, 0);

        // staggered I then Q
        tick_i(16'h1234);
        step(); step();
        tick_q(16'hFEDC);
        step();
        check("stagger_data", {bus.iq_I, bus.iq_Q}, 32'h1234FEDC);
        check("stagger_no_err", bus.pair_err, 0);
        pop();
        check("stagger_single", bus.iq_valid, 0);

        // repeated I before Q
        tick_i(16'h1111);
        tick_i(16'h2222);
        tick_q(16'h3333);
        check("perr_set", bus.pair_err, 1);
        check("perr_data", {bus.iq_I, bus.iq_Q}, 32'h22223333);
        pop();
        clear();
        check("perr_cleared", bus.pair_err, 0);

        // set beats clear in the same cycle
        tick_i(16'h0101);
        bus.clr_status = 1'b1;
        tick_i(16'h0202);
        bus.clr_status = 1'b0;
        check("perr_set_wins", bus.pair_err, 1);
        tick_q(16'h0303);
        check("perr2_data", {bus.iq_I, bus.iq_Q}, 32'h02020303);
        pop();
        clear();

        // reset mid-stream with 3 entries buffered
        for (int k = 0; k < 3; k++) pair(16'(16'h0700 + k), 16'h0);
        check("pre_rst_valid", bus.iq_valid, 1);
        RSTb = 1'b0;
        #1;
        check("async_rst_valid", bus.iq_valid, 0);
        check("async_rst_inc", bus.nco_phase_inc, DEF_INC);
        check("async_rst_busy", bus.tune_busy, 1);
        step();
        RSTb = 1'b1;
        for (int k = 0; k < 8; k++) begin
            pair(16'(k), 16'(k));
            if (k == 6) check("rst_settle7_busy", bus.tune_busy, 1);
        end
        check("rst_settle_valid", bus.iq_valid, 0);
        check("rst_settle8_busy", bus.tune_busy, 0);
        pair(16'h0999, 16'h0888);
        check("rst_first_data", {bus.iq_valid, bus.iq_I, bus.iq_Q}, {1'b1, 32'h09990888});

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
